// File: rtl/exmem_mem_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : exmem_mem_stage_if
//  Purpose  : Ready-handshake data-memory bus between the MEM stage and memory.
//  Revision : 1.0  initial release
// ============================================================================
interface exmem_mem_stage_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/exmem_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : exmem_mem_stage
//  Purpose  : EX/MEM pipeline register with a load/store sequencer and timeout.
//  Revision : 1.0  initial release
// ============================================================================
module exmem_mem_stage #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        valid_ex_i,
    input  wire logic        flush_i,
    input  wire logic        memread_ex_i,
    input  wire logic        memwrite_ex_i,
    input  wire logic        memtoreg_ex_i,
    input  wire logic        regwrite_ex_i,
    input  wire logic [1:0]  size_ex_i,
    input  wire logic        unsigned_ex_i,
    input  wire logic [31:0] aluout_ex_i,
    input  wire logic [31:0] storedata_ex_i,
    input  wire logic [4:0]  rw_ex_i,
    output logic             stall_o,
    exmem_mem_stage_if.master bus,
    output logic             memtoreg_exmem_o,
    output logic             regwrite_exmem_o,
    output logic [31:0]      memout_o,
    output logic [31:0]      aluout_o,
    output logic [4:0]       mem_rw_o,
    output logic             misalign_o,
    output logic             buserr_o
);
    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT - 1);

    function automatic logic f_bad(input logic [1:0] size, input logic [1:0] a);
        return (size == 2'b11) || (size == 2'b01 && a[0]) || (size == 2'b10 && a != 2'b00);
    endfunction

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic        h_valid_q, h_rd_q, h_wr_q, h_memtoreg_q, h_regwrite_q, h_unsigned_q;
    logic [1:0]  h_size_q;
    logic [31:0] h_alu_q, h_sdata_q;
    logic [4:0]  h_rw_q;

    logic        regwrite_q, memtoreg_q, misalign_q, buserr_q;
    logic [31:0] memout_q, aluout_q;
    logic [4:0]  rw_q;

    logic        w_in_good_mem, w_h_is_mem, w_h_bad, w_in_access, w_at_last;
    logic        w_timeout, w_done, w_stall, w_load_ok;
    logic [31:0] w_lane, w_load;

    assign w_in_good_mem = valid_ex_i & ~flush_i & (memread_ex_i | memwrite_ex_i)
                         & ~f_bad(size_ex_i, aluout_ex_i[1:0]);
    assign w_h_is_mem    = h_valid_q & (h_rd_q | h_wr_q);
    assign w_h_bad       = w_h_is_mem & f_bad(h_size_q, h_alu_q[1:0]);
    assign w_in_access   = (state_q == S_ACCESS);
    assign w_at_last     = (cnt_q == C_LAST);
    // A ready in the final wait cycle completes normally rather than timing out.
    assign w_timeout     = w_in_access & w_at_last & ~bus.mem_ready;
    assign w_done        = h_valid_q & (~w_h_is_mem | w_h_bad | bus.mem_ready | w_at_last);
    assign w_stall       = w_in_access & ~bus.mem_ready & ~w_at_last;
    assign w_load_ok     = w_in_access & h_rd_q & bus.mem_ready;
    assign stall_o       = w_stall;

    assign bus.mem_req   = w_in_access;
    assign bus.mem_we    = h_wr_q;
    assign bus.mem_addr  = {h_alu_q[31:2], 2'b00};

    always_comb begin
        bus.mem_be    = 4'b1111;
        bus.mem_wdata = h_sdata_q;
        w_lane        = bus.mem_rdata >> {h_alu_q[1:0], 3'b000};
        w_load        = w_lane;
        case (h_size_q)
            2'b00: begin
                bus.mem_be    = 4'b0001 << h_alu_q[1:0];
                bus.mem_wdata = {4{h_sdata_q[7:0]}};
                w_load        = h_unsigned_q ? {24'd0, w_lane[7:0]} : {{24{w_lane[7]}}, w_lane[7:0]};
            end
            2'b01: begin
                bus.mem_be    = 4'b0011 << h_alu_q[1:0];
                bus.mem_wdata = {2{h_sdata_q[15:0]}};
                w_load        = h_unsigned_q ? {16'd0, w_lane[15:0]} : {{16{w_lane[15]}}, w_lane[15:0]};
            end
            default: ;
        endcase
    end

    // Whenever the stage is not stalled a new instruction is captured, so the
    // FSM decision is made purely on what arrives from EX this edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (w_stall) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d   = '0;
            state_d = w_in_good_mem ? S_ACCESS : S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_valid_q    <= 1'b0;
            h_rd_q       <= 1'b0;
            h_wr_q       <= 1'b0;
            h_memtoreg_q <= 1'b0;
            h_regwrite_q <= 1'b0;
            h_unsigned_q <= 1'b0;
            h_size_q     <= 2'b00;
            h_alu_q      <= 32'd0;
            h_sdata_q    <= 32'd0;
            h_rw_q       <= 5'd0;
        end else if (!w_stall) begin
            h_valid_q    <= valid_ex_i & ~flush_i;
            h_rd_q       <= memread_ex_i;
            h_wr_q       <= memwrite_ex_i;
            h_memtoreg_q <= memtoreg_ex_i;
            h_regwrite_q <= regwrite_ex_i;
            h_unsigned_q <= unsigned_ex_i;
            h_size_q     <= size_ex_i;
            h_alu_q      <= aluout_ex_i;
            h_sdata_q    <= storedata_ex_i;
            h_rw_q       <= rw_ex_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            misalign_q <= 1'b0;
            buserr_q   <= 1'b0;
            memout_q   <= 32'd0;
            aluout_q   <= 32'd0;
            rw_q       <= 5'd0;
        end else begin
            misalign_q <= w_done & w_h_bad;
            buserr_q   <= w_done & w_timeout;
            if (w_done) begin
                regwrite_q <= h_regwrite_q & ~w_h_bad & ~w_timeout;
                memtoreg_q <= h_memtoreg_q;
                aluout_q   <= h_alu_q;
                rw_q       <= h_rw_q;
                if (w_load_ok) memout_q <= w_load;
            end else begin
                regwrite_q <= 1'b0;
                memtoreg_q <= 1'b0;
            end
        end
    end

    assign regwrite_exmem_o = regwrite_q;
    assign memtoreg_exmem_o = memtoreg_q;
    assign misalign_o       = misalign_q;
    assign buserr_o         = buserr_q;
    assign memout_o         = memout_q;
    assign aluout_o         = aluout_q;
    assign mem_rw_o         = rw_q;
endmodule
`default_nettype wire

// File: tb/tb_exmem_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_exmem_mem_stage
//  Purpose  : Scoreboard bench for exmem_mem_stage with a wait-state memory.
//  Revision : 1.0  initial release
// ============================================================================
module tb_exmem_mem_stage;
    localparam int C_TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_ex, flush, rd, wr, m2r, rwen, uns;
    logic [1:0]  size;
    logic [31:0] alu_ex, sdata;
    logic [4:0]  rw_ex;
    logic        stall, memtoreg_o, regwrite_o, misalign_o, buserr_o;
    logic [31:0] memout_o, aluout_o;
    logic [4:0]  mem_rw_o;

    exmem_mem_stage_if bus_if ();

    exmem_mem_stage #(.TIMEOUT(C_TIMEOUT), .CNT_W(5)) dut (
        .clk              (clk),
        .rst              (rst),
        .valid_ex_i       (valid_ex),
        .flush_i          (flush),
        .memread_ex_i     (rd),
        .memwrite_ex_i    (wr),
        .memtoreg_ex_i    (m2r),
        .regwrite_ex_i    (rwen),
        .size_ex_i        (size),
        .unsigned_ex_i    (uns),
        .aluout_ex_i      (alu_ex),
        .storedata_ex_i   (sdata),
        .rw_ex_i          (rw_ex),
        .stall_o          (stall),
        .bus              (bus_if),
        .memtoreg_exmem_o (memtoreg_o),
        .regwrite_exmem_o (regwrite_o),
        .memout_o         (memout_o),
        .aluout_o         (aluout_o),
        .mem_rw_o         (mem_rw_o),
        .misalign_o       (misalign_o),
        .buserr_o         (buserr_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rw_en;
        logic        m2r;
        logic [31:0] alu;
        logic [4:0]  rw;
        logic [31:0] mout;
        logic        mis;
        logic        berr;
    } res_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;

    res_t        res_q[$];
    bus_t        bus_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cur_waits = 0;
    logic [31:0] cur_rdata = 32'd0;
    logic [31:0] last_mout = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Memory responder: checks each new request, then answers after cur_waits cycles.
    initial begin
        int   wc;
        bit   in_req;
        bus_t b;
        wc = 0;
        in_req = 1'b0;
        bus_if.mem_ready = 1'b0;
        bus_if.mem_rdata = 32'd0;
        forever begin
            @(posedge clk);
            #2;
            bus_if.mem_ready = 1'b0;
            if (bus_if.mem_req) begin
                if (!in_req) begin
                    in_req = 1'b1;
                    wc     = 0;
                    if (bus_q.size() == 0) begin
                        chk("unexpected_req", {31'd0, bus_if.mem_req}, 32'd0);
                    end else begin
                        b = bus_q.pop_front();
                        chk("bus_we",   {31'd0, bus_if.mem_we}, {31'd0, b.we});
                        chk("bus_addr", bus_if.mem_addr, b.addr);
                        if (b.we) begin
                            chk("bus_be",    {28'd0, bus_if.mem_be}, {28'd0, b.be});
                            chk("bus_wdata", bus_if.mem_wdata, b.wdata);
                        end
                    end
                end
                if (wc == cur_waits) begin
                    bus_if.mem_ready = 1'b1;
                    bus_if.mem_rdata = cur_rdata;
                    in_req           = 1'b0;
                end else begin
                    wc++;
                end
            end else begin
                in_req = 1'b0;
            end
        end
    end

    // Result monitor: every visible completion pops one scoreboard entry.
    initial begin
        res_t r;
        forever begin
            @(negedge clk);
            if (!rst && (regwrite_o || misalign_o || buserr_o)) begin
                if (res_q.size() == 0) begin
                    chk("unexpected_result", {29'd0, misalign_o, buserr_o, regwrite_o}, 32'd0);
                end else begin
                    r = res_q.pop_front();
                    chk("regwrite", {31'd0, regwrite_o}, {31'd0, r.rw_en});
                    chk("memtoreg", {31'd0, memtoreg_o}, {31'd0, r.m2r});
                    chk("aluout",   aluout_o, r.alu);
                    chk("mem_rw",   {27'd0, mem_rw_o}, {27'd0, r.rw});
                    chk("memout",   memout_o, r.mout);
                    chk("misalign", {31'd0, misalign_o}, {31'd0, r.mis});
                    chk("buserr",   {31'd0, buserr_o}, {31'd0, r.berr});
                end
            end
        end
    end

    task automatic issue(input string tag, input logic i_rd, input logic i_wr, input logic i_m2r,
                         input logic i_rwen, input logic [1:0] i_size, input logic i_uns,
                         input logic [31:0] i_addr, input logic [31:0] i_sdata, input logic [4:0] i_rw,
                         input int waits, input logic [31:0] rdata, input logic i_flush,
                         input int exp_stall);
        logic        bad, timed, good;
        logic [31:0] lane, ld;
        res_t        r;
        bus_t        b;
        int          st;
        bad   = (i_rd | i_wr) & ((i_size == 2'b11) || (i_size == 2'b01 && i_addr[0])
                                 || (i_size == 2'b10 && i_addr[1:0] != 2'b00));
        good  = (i_rd | i_wr) & ~bad;
        timed = good && (waits >= C_TIMEOUT);
        @(negedge clk);
        valid_ex = 1'b1; flush = i_flush; rd = i_rd; wr = i_wr; m2r = i_m2r; rwen = i_rwen;
        size = i_size; uns = i_uns; alu_ex = i_addr; sdata = i_sdata; rw_ex = i_rw;
        cur_waits = waits;
        cur_rdata = rdata;
        if (!i_flush) begin
            if (good) begin
                b.we    = i_wr;
                b.addr  = {i_addr[31:2], 2'b00};
                case (i_size)
                    2'b00:   begin b.be = 4'b0001 << i_addr[1:0]; b.wdata = {4{i_sdata[7:0]}};  end
                    2'b01:   begin b.be = 4'b0011 << i_addr[1:0]; b.wdata = {2{i_sdata[15:0]}}; end
                    default: begin b.be = 4'b1111;                b.wdata = i_sdata;            end
                endcase
                bus_q.push_back(b);
            end
            if (i_rd && good && !timed) begin
                lane = rdata >> (8 * i_addr[1:0]);
                case (i_size)
                    2'b00:   ld = i_uns ? {24'd0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
                    2'b01:   ld = i_uns ? {16'd0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
                    default: ld = lane;
                endcase
                last_mout = ld;
            end
            r.rw_en = i_rwen & ~bad & ~timed;
            r.m2r   = i_m2r;
            r.alu   = i_addr;
            r.rw    = i_rw;
            r.mout  = last_mout;
            r.mis   = bad;
            r.berr  = timed;
            if (r.rw_en || r.mis || r.berr) res_q.push_back(r);
        end
        @(posedge clk);
        #1;
        valid_ex = 1'b0;
        flush    = 1'b0;
        st = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!stall) break;
            st++;
        end
        chk({tag, "_stall_cycles"}, st, exp_stall);
        repeat (2) @(negedge clk);
        #1;
        chk({tag, "_drained"}, res_q.size() + bus_q.size(), 32'd0);
        chk({tag, "_bubble"}, {28'd0, regwrite_o, memtoreg_o, misalign_o, buserr_o}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        valid_ex = 1'b0; flush = 1'b0; rd = 1'b0; wr = 1'b0; m2r = 1'b0; rwen = 1'b0;
        size = 2'b00; uns = 1'b0; alu_ex = 32'd0; sdata = 32'd0; rw_ex = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_regwrite", {31'd0, regwrite_o}, 32'd0);
        chk("rst_memtoreg", {31'd0, memtoreg_o}, 32'd0);
        chk("rst_memout",   memout_o, 32'd0);
        chk("rst_aluout",   aluout_o, 32'd0);
        chk("rst_mem_rw",   {27'd0, mem_rw_o}, 32'd0);
        chk("rst_pulses",   {30'd0, misalign_o, buserr_o}, 32'd0);
        chk("rst_mem_req",  {31'd0, bus_if.mem_req}, 32'd0);
        chk("rst_stall",    {31'd0, stall}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        //          tag         rd wr m2r rwen size  uns addr          sdata         rw  waits rdata          flush stall
        issue("add",       0, 0, 0, 1, 2'b10, 0, 32'h0000_1234, 32'd0,        5'd5,  0, 32'd0,          0, 0);
        issue("lb",        1, 0, 1, 1, 2'b00, 0, 32'h0000_0103, 32'd0,        5'd8,  0, 32'h80FF_FFFF,  0, 0);
        issue("lbu",       1, 0, 1, 1, 2'b00, 1, 32'h0000_0103, 32'd0,        5'd9,  0, 32'h80FF_FFFF,  0, 0);
        issue("lh",        1, 0, 1, 1, 2'b01, 0, 32'h0000_0002, 32'd0,        5'd10, 1, 32'h8001_1234,  0, 1);
        issue("lw",        1, 0, 1, 1, 2'b10, 0, 32'h0000_0040, 32'd0,        5'd11, 2, 32'hDEAD_BEEF,  0, 2);
        issue("sh",        0, 1, 0, 0, 2'b01, 0, 32'h0000_0202, 32'h0000_ABCD, 5'd0,  3, 32'd0,          0, 3);
        issue("sb",        0, 1, 0, 0, 2'b00, 0, 32'h0000_0101, 32'h1234_565A, 5'd0,  0, 32'd0,          0, 0);
        issue("sub",       0, 0, 0, 1, 2'b10, 0, 32'hFFFF_FFF0, 32'd0,        5'd31, 0, 32'd0,          0, 0);
        issue("lw_mis",    1, 0, 1, 1, 2'b10, 0, 32'h0000_0006, 32'd0,        5'd12, 0, 32'd0,          0, 0);
        issue("lh_mis",    1, 0, 1, 1, 2'b01, 1, 32'h0000_0011, 32'd0,        5'd13, 0, 32'd0,          0, 0);
        issue("l_rsvd",    1, 0, 1, 1, 2'b11, 0, 32'h0000_0000, 32'd0,        5'd14, 0, 32'd0,          0, 0);
        issue("sw_mis",    0, 1, 0, 0, 2'b10, 0, 32'h0000_0002, 32'h5555_AAAA, 5'd0,  0, 32'd0,          0, 0);
        issue("flushed",   1, 0, 1, 1, 2'b10, 0, 32'h0000_0080, 32'd0,        5'd15, 0, 32'd0,          1, 0);
        issue("lw_tmo",    1, 0, 1, 1, 2'b10, 0, 32'h0000_0100, 32'd0,        5'd16, 100, 32'd0,        0, 15);
        issue("lw_last",   1, 0, 1, 1, 2'b10, 0, 32'h0000_0104, 32'd0,        5'd17, 15, 32'h0BAD_F00D, 0, 15);

        // Reset in the middle of an access abandons it.
        @(negedge clk);
        valid_ex = 1'b1; rd = 1'b1; wr = 1'b0; m2r = 1'b1; rwen = 1'b1; size = 2'b10;
        alu_ex = 32'h0000_0200; rw_ex = 5'd18; cur_waits = 100;
        bus_q.push_back('{we: 1'b0, addr: 32'h0000_0200, be: 4'b1111, wdata: 32'd0});
        @(posedge clk);
        #1;
        valid_ex = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_req", {31'd0, bus_if.mem_req}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_req",   {31'd0, bus_if.mem_req}, 32'd0);
        chk("post_rst_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        res_q.delete();
        last_mout = 32'd0;
        repeat (3) @(negedge clk);
        chk("post_rst_regwrite", {31'd0, regwrite_o}, 32'd0);
        chk("post_rst_memout",   memout_o, 32'd0);
        issue("add2",      0, 0, 0, 1, 2'b10, 0, 32'h0000_0777, 32'd0,        5'd3,  0, 32'd0,          0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
